wb_slave_decoder: RTL

Single-master, multi-slave Wishbone address decoder with a bus watchdog, placed directly upstream of the software-register slaves (read-only and write sw_reg blocks) on the `wb_clk_i` domain. It registers each master request, decodes it against per-slave address windows, and forwards it to exactly one slave. It returns that slave's ack, error and read data to the master. Unmapped addresses and slaves that never acknowledge are terminated with an error so that the master never hangs.

---
 rtl/wb_slave_decoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: registered single-master Wishbone decoder with per-slave address windows and a response watchdog.
module wb_slave_decoder #(
    parameter int                         NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_ADDR = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK = {4{32'hFFFF_0000}},
    parameter int                         TIMEOUT    = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_we_i,
    input  logic [3:0]                   wbm_sel_i,
    input  logic [31:0]                  wbm_adr_i,
    input  logic [31:0]                  wbm_dat_i,
    output logic [31:0]                  wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic                         wbs_we_o,
    output logic [3:0]                   wbs_sel_o,
    output logic [31:0]                  wbs_adr_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic [32*NUM_SLAVES-1:0]     wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
    state_t                 state, state_n;
    logic [NUM_SLAVES-1:0]  dec;
    logic [31:0]            rd_mux, rd_cap;
    logic [15:0]            cnt;
    logic                   req, sel_ack, sel_err, expired, resp_err;

    assign req       = wbm_cyc_i & wbm_stb_i;
    assign sel_ack   = |(wbs_ack_i & wbs_cyc_o);
    assign sel_err   = |(wbs_err_i & wbs_cyc_o);
    assign expired   = cnt == LAST;
    assign wbs_stb_o = wbs_cyc_o;

    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        dec    = '0;
        rd_mux = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((wbm_adr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_ADDR[32*i +: 32]) begin
                dec    = '0;
                dec[i] = 1'b1;
            end
            if (wbs_cyc_o[i]) rd_mux = rd_mux | wbs_dat_i[32*i +: 32];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? (|dec ? WAIT : RESP) : IDLE;
            WAIT:    state_n = !wbm_cyc_i ? IDLE : (sel_ack | sel_err | expired) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        state <= wb_rst_i ? IDLE : state_n;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbs_cyc_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_sel_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            rd_cap    <= '0;
            resp_err  <= 1'b0;
            cnt       <= '0;
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    wbs_adr_o <= wbm_adr_i;
                    wbs_dat_o <= wbm_dat_i;
                    wbs_sel_o <= wbm_sel_i;
                    wbs_we_o  <= wbm_we_i;
                    wbs_cyc_o <= dec;
                    resp_err  <= ~|dec;
                    cnt       <= '0;
                end
                WAIT: begin
                    cnt      <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                    resp_err <= sel_err | ~sel_ack;
                    rd_cap   <= rd_mux;
                    if (state_n != WAIT) wbs_cyc_o <= '0;
                end
                RESP: begin
                    wbm_ack_o <= ~resp_err;
                    wbm_err_o <= resp_err;
                    wbm_dat_o <= (resp_err | wbs_we_o) ? 32'h0 : rd_cap;
                end
                default: wbs_cyc_o <= '0;
            endcase
        end
    end
endmodule
